// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : booth_mult_seq
// Purpose  : Sequential Booth multiplier, one recode step per clock.
//            RADIX4=0 gives radix-2 Booth with 1 multiplier bit per step.
//            RADIX4=1 gives radix-4 modified Booth with 2 bits per step.
//            The signed/unsigned choice is made per operation.
// Ports    : clk          - clock; all state changes on the rising edge
//            rst          - synchronous active-high reset
//            start        - request; only sampled when not busy
//            signed_mode  - 1 = two's-complement operands (captured with start)
//            multiplicand - operand A (captured with start)
//            multiplier   - operand B (captured with start)
//            busy         - high while an operation is running
//            done         - one-cycle pulse when product is valid
//            product      - A*B, held until the next accepted start
// Revision : 1.0  initial parameterised release
// ============================================================================
module booth_mult_seq #(
  parameter int WIDTH  = 8,
  parameter int RADIX4 = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  // Operands are widened by one (radix-2) or two (radix-4) bits. The extra
  // bit lets unsigned values be recoded as positive two's-complement
  // numbers. Radix-4 needs an even operand length, so it adds a second bit.
  localparam int M     = (RADIX4 != 0) ? WIDTH + 2 : WIDTH + 1;
  localparam int STEPS = (RADIX4 != 0) ? (WIDTH + 2) / 2 : WIDTH + 1;
  localparam int EXT   = M - WIDTH;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [M:0]           acc_q, acc_d;
  logic [M-1:0]         a_q, a_d;
  logic [M-1:0]         q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic [M-1:0]         w_a_ext;
  logic [M-1:0]         w_b_ext;
  logic [M:0]           w_a1;
  logic [M:0]           w_sum;
  logic [M:0]           w_step_acc;
  logic [M-1:0]         w_step_q;
  logic                 w_step_qm1;

  // Unsigned operands get zero fill; signed operands replicate their MSB.
  assign w_a_ext = {{EXT{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
  assign w_b_ext = {{EXT{signed_mode & multiplier[WIDTH-1]}}, multiplier};

  // The accumulator is one bit wider than A, so A is sign-extended once.
  assign w_a1    = {a_q[M-1], a_q};

  if (RADIX4 != 0) begin : g_radix4
    logic [M:0] w_a2;
    assign w_a2 = {a_q, 1'b0};

    always_comb begin
      w_sum = acc_q;
      case ({q_q[1:0], qm1_q})
        3'b001, 3'b010: w_sum = acc_q + w_a1;
        3'b011:         w_sum = acc_q + w_a2;
        3'b100:         w_sum = acc_q - w_a2;
        3'b101, 3'b110: w_sum = acc_q - w_a1;
        default:        w_sum = acc_q;
      endcase
      // Arithmetic right shift of {acc,Q,q-1} by two.
      w_step_acc = {{2{w_sum[M]}}, w_sum[M:2]};
      w_step_q   = {w_sum[1:0], q_q[M-1:2]};
      w_step_qm1 = q_q[1];
    end
  end else begin : g_radix2
    always_comb begin
      w_sum = acc_q;
      case ({q_q[0], qm1_q})
        2'b01:   w_sum = acc_q + w_a1;
        2'b10:   w_sum = acc_q - w_a1;
        default: w_sum = acc_q;
      endcase
      // Arithmetic right shift of {acc,Q,q-1} by one.
      w_step_acc = {w_sum[M], w_sum[M:1]};
      w_step_q   = {w_sum[0], q_q[M-1:1]};
      w_step_qm1 = q_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;

    case (state_q)
      // DONE accepts a new start exactly like IDLE. This allows
      // back-to-back operations with no gap cycle.
      S_IDLE, S_DONE: begin
        if (start) begin
          acc_d   = '0;
          a_d     = w_a_ext;
          q_d     = w_b_ext;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = w_step_acc;
        q_d   = w_step_q;
        qm1_d = w_step_qm1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          // Low 2*WIDTH bits of the final {acc,Q}. M < 2*WIDTH always holds.
          prod_d  = {w_step_acc[2*WIDTH-M-1:0], w_step_q};
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = prod_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_mult_seq
// Purpose  : Self-checking bench for booth_mult_seq. It runs six instances:
//            WIDTH 8/4/16, each with radix-2 and radix-4. All instances share
//            the operand bus and the mode input. Each instance has its own
//            start line. Expected products are queued per instance and are
//            compared whenever that instance pulses done.
// Revision : 1.0  initial release
// ============================================================================
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  start_v = '0;
  logic        sm_r = 1'b0;
  logic [15:0] a_r = '0;
  logic [15:0] b_r = '0;

  logic [5:0]  done_v;
  logic [5:0]  busy_v;
  logic [15:0] p0, p1;
  logic [7:0]  p2, p3;
  logic [31:0] p4, p5;
  logic [31:0] prod_v [6];

  logic [31:0] exp_q [6][$];
  logic [31:0] e_mon;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  // Instance map: 0=W8/R2 1=W8/R4 2=W4/R2 3=W4/R4 4=W16/R2 5=W16/R4
  booth_mult_seq #(.WIDTH(8), .RADIX4(0)) u_w8r2 (
    .clk(clk), .rst(rst), .start(start_v[0]), .signed_mode(sm_r),
    .multiplicand(a_r[7:0]), .multiplier(b_r[7:0]),
    .busy(busy_v[0]), .done(done_v[0]), .product(p0));
  booth_mult_seq #(.WIDTH(8), .RADIX4(1)) u_w8r4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .signed_mode(sm_r),
    .multiplicand(a_r[7:0]), .multiplier(b_r[7:0]),
    .busy(busy_v[1]), .done(done_v[1]), .product(p1));
  booth_mult_seq #(.WIDTH(4), .RADIX4(0)) u_w4r2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .signed_mode(sm_r),
    .multiplicand(a_r[3:0]), .multiplier(b_r[3:0]),
    .busy(busy_v[2]), .done(done_v[2]), .product(p2));
  booth_mult_seq #(.WIDTH(4), .RADIX4(1)) u_w4r4 (
    .clk(clk), .rst(rst), .start(start_v[3]), .signed_mode(sm_r),
    .multiplicand(a_r[3:0]), .multiplier(b_r[3:0]),
    .busy(busy_v[3]), .done(done_v[3]), .product(p3));
  booth_mult_seq #(.WIDTH(16), .RADIX4(0)) u_w16r2 (
    .clk(clk), .rst(rst), .start(start_v[4]), .signed_mode(sm_r),
    .multiplicand(a_r), .multiplier(b_r),
    .busy(busy_v[4]), .done(done_v[4]), .product(p4));
  booth_mult_seq #(.WIDTH(16), .RADIX4(1)) u_w16r4 (
    .clk(clk), .rst(rst), .start(start_v[5]), .signed_mode(sm_r),
    .multiplicand(a_r), .multiplier(b_r),
    .busy(busy_v[5]), .done(done_v[5]), .product(p5));

  assign prod_v[0] = {16'h0000, p0};
  assign prod_v[1] = {16'h0000, p1};
  assign prod_v[2] = {24'h000000, p2};
  assign prod_v[3] = {24'h000000, p3};
  assign prod_v[4] = p4;
  assign prod_v[5] = p5;

  function automatic int w_of(input int i);
    case (i)
      0, 1:    return 8;
      2, 3:    return 4;
      default: return 16;
    endcase
  endfunction

  // Reference model: extend the operands per mode, multiply as integers,
  // then truncate to 2*w bits.
  function automatic logic [31:0] ref_prod(input int w, input logic sm,
                                           input logic [15:0] a, input logic [15:0] b);
    longint mask, sa, sb, p;
    mask = (longint'(1) << w) - 1;
    sa = longint'(a) & mask;
    sb = longint'(b) & mask;
    if (sm && sa[w-1]) sa = sa - (longint'(1) << w);
    if (sm && sb[w-1]) sb = sb - (longint'(1) << w);
    p = (sa * sb) & ((longint'(1) << (2 * w)) - 1);
    return p[31:0];
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < 6; i++) n += exp_q[i].size();
    return n;
  endfunction

  // Scoreboard: every done pulse consumes one expected product.
  always @(negedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (done_v[i]) begin
        checks++;
        if (exp_q[i].size() == 0) begin
          failures++;
          $display("FAIL unexpected_done inst=%0d product=%h required=no_done", i, prod_v[i]);
        end else begin
          e_mon = exp_q[i].pop_front();
          if (prod_v[i] !== e_mon) begin
            failures++;
            $display("FAIL product inst=%0d got=%h want=%h", i, prod_v[i], e_mon);
          end
        end
      end
    end
  end

  // Raises start for one instance and queues its expected product.
  // The caller supplies the capture edge.
  task automatic arm(input int i, input logic [31:0] expv);
    start_v[i] = 1'b1;
    exp_q[i].push_back(expv);
  endtask

  task automatic launch_edge();
    @(posedge clk);
    #1;
    start_v = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy_v != 6'b0 || done_v != 6'b0 || pending() != 0) && n < 200);
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL idle_timeout busy=%b pending=%0d required=idle", busy_v, pending());
      for (int i = 0; i < 6; i++) exp_q[i].delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_v = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy_v !== 6'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b want=000000", busy_v);
    end
    checks++;
    if (done_v !== 6'b0) begin
      failures++;
      $display("FAIL reset_done got=%b want=000000", done_v);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (prod_v[i] !== 32'h0) begin
        failures++;
        $display("FAIL reset_product inst=%0d got=%h want=0", i, prod_v[i]);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_radix2_signed();
    int n = 0;
    int nb = 0;
    sm_r = 1'b1; a_r = 16'h00F9; b_r = 16'h0003;
    arm(0, 32'h0000FFEB);
    launch_edge();
    do begin
      @(negedge clk);
      n++;
      if (busy_v[0]) nb++;
    end while (!done_v[0] && n < 100);
    checks++;
    if (n != 10) begin
      failures++;
      $display("FAIL r2_latency got=%0d want=10", n);
    end
    checks++;
    if (nb != 9) begin
      failures++;
      $display("FAIL r2_busy_cycles got=%0d want=9", nb);
    end
    wait_idle();
  endtask

  task automatic test_radix4_extremes();
    logic [15:0] bs [2];
    logic [31:0] es [2];
    bs[0] = 16'h0080; es[0] = 32'h00004000;
    bs[1] = 16'h007F; es[1] = 32'h0000C080;
    for (int k = 0; k < 2; k++) begin
      int n = 0;
      int nb = 0;
      sm_r = 1'b1; a_r = 16'h0080; b_r = bs[k];
      arm(1, es[k]);
      launch_edge();
      do begin
        @(negedge clk);
        n++;
        if (busy_v[1]) nb++;
      end while (!done_v[1] && n < 100);
      checks++;
      if (n != 6) begin
        failures++;
        $display("FAIL r4_latency case=%0d got=%0d want=6", k, n);
      end
      checks++;
      if (nb != 5) begin
        failures++;
        $display("FAIL r4_busy_cycles case=%0d got=%0d want=5", k, nb);
      end
      wait_idle();
    end
  endtask

  task automatic test_unsigned_vs_signed();
    sm_r = 1'b0; a_r = 16'h00FF; b_r = 16'h00FF;
    arm(0, 32'h0000FE01);
    arm(1, 32'h0000FE01);
    launch_edge();
    wait_idle();
    sm_r = 1'b1;
    arm(0, 32'h00000001);
    arm(1, 32'h00000001);
    launch_edge();
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [15:0] as_t [3];
    logic [15:0] bs_t [3];
    as_t[0] = 16'h0005; bs_t[0] = 16'h0006;
    as_t[1] = 16'h0000; bs_t[1] = 16'h00FF;
    as_t[2] = 16'h00FF; bs_t[2] = 16'h00FF;
    exp_q[0].push_back(32'h0000001E);
    exp_q[0].push_back(32'h00000000);
    exp_q[0].push_back(32'h00000001);
    sm_r = 1'b1; a_r = as_t[0]; b_r = bs_t[0];
    start_v[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      @(posedge clk);
      #1;
      // These operand changes happen while the operation runs and must not matter.
      a_r = 16'($urandom); b_r = 16'($urandom); sm_r = 1'($urandom);
      do begin
        @(negedge clk);
        n++;
      end while (!done_v[0] && n < 100);
      checks++;
      if (n != 10) begin
        failures++;
        $display("FAIL b2b_interval op=%0d got=%0d want=10", k, n);
      end
      if (k < 2) begin
        sm_r = 1'b1; a_r = as_t[k+1]; b_r = bs_t[k+1];
      end else begin
        start_v[0] = 1'b0;
      end
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_op();
    sm_r = 1'b0; a_r = 16'd100; b_r = 16'd100;
    start_v[0] = 1'b1;
    launch_edge();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy got=%b want=0", busy_v[0]);
    end
    checks++;
    if (done_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort_done got=%b want=0", done_v[0]);
    end
    checks++;
    if (prod_v[0] !== 32'h0) begin
      failures++;
      $display("FAIL abort_product got=%h want=0", prod_v[0]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    sm_r = 1'b1; a_r = 16'd2; b_r = 16'd3;
    arm(0, 32'h00000006);
    launch_edge();
    wait_idle();
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 9))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      4: return 16'h8088;
      5: return 16'h7F77;
      6: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_random_sweep();
    for (int r = 0; r < 1700; r++) begin
      sm_r = 1'($urandom);
      a_r = pick();
      b_r = pick();
      for (int i = 0; i < 6; i++) arm(i, ref_prod(w_of(i), sm_r, a_r, b_r));
      launch_edge();
      wait_idle();
    end
  endtask

  initial begin
    test_reset();
    test_radix2_signed();
    test_radix4_extremes();
    test_unsigned_vs_signed();
    test_back_to_back();
    test_reset_mid_op();
    test_random_sweep();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
